// File: rtl/mult_share_sequencer.sv
// Round-robin sequencer sharing one signed shift-add multiplier datapath between two requesters.
// It grants a requester, runs one full multiply on the datapath, and returns the product with the requester ID.
module mult_share_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic [1:0]           req_valid,
   output logic [1:0]           req_ready,
   input  logic [WIDTH-1:0]     req_a0,
   input  logic [WIDTH-1:0]     req_b0,
   input  logic [WIDTH-1:0]     req_a1,
   input  logic [WIDTH-1:0]     req_b1,
   output logic [WIDTH-1:0]     dp_S,
   output logic [WIDTH-1:0]     dp_B,
   output logic                 Ld_B,
   output logic                 Clr_XA,
   output logic                 Add,
   output logic                 Sub,
   output logic                 Shift_En,
   input  logic                 M,
   input  logic [2*WIDTH-1:0]   product_in,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic                 resp_id,
   output logic [2*WIDTH-1:0]   resp_data,
   output logic                 busy,
   output logic [15:0]          job_count,
   output logic [2:0]           dbg_state
);

   localparam int STEP_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_ADD   = 3'd2,
      S_SHIFT = 3'd3,
      S_CAPT  = 3'd4,
      S_RESP  = 3'd5
   } state_t;

   state_t               state_q, state_d;
   logic [STEP_W-1:0]    step_q, step_d;
   logic                 last_grant_q, last_grant_d;
   logic [WIDTH-1:0]     dp_s_q, dp_s_d;
   logic [WIDTH-1:0]     dp_b_q, dp_b_d;
   logic                 resp_id_q, resp_id_d;
   logic [2*WIDTH-1:0]   resp_data_q, resp_data_d;
   logic                 resp_valid_q, resp_valid_d;
   logic [15:0]          job_count_q, job_count_d;
   logic                 busy_q;
   logic [1:0]           grant;

   // valid/ready: a transfer happens on the Clk edge where valid and ready are both high;
   // the sender keeps valid and its payload steady until that edge.
   always_comb begin
      grant        = 2'b00;
      req_ready    = 2'b00;
      Ld_B         = 1'b0;
      Clr_XA       = 1'b0;
      Add          = 1'b0;
      Sub          = 1'b0;
      Shift_En     = 1'b0;
      state_d      = state_q;
      step_d       = step_q;
      last_grant_d = last_grant_q;
      dp_s_d       = dp_s_q;
      dp_b_d       = dp_b_q;
      resp_id_d    = resp_id_q;
      resp_data_d  = resp_data_q;
      resp_valid_d = resp_valid_q;
      job_count_d  = job_count_q;

      case (req_valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase

      case (state_q)
         S_IDLE: begin
            req_ready = grant;
            if (grant != 2'b00) begin
               last_grant_d = grant[1];
               resp_id_d    = grant[1];
               dp_s_d       = grant[1] ? req_a1 : req_a0;
               dp_b_d       = grant[1] ? req_b1 : req_b0;
               state_d      = S_LOAD;
            end
         end
         S_LOAD: begin
            Ld_B    = 1'b1;
            Clr_XA  = 1'b1;
            step_d  = '0;
            state_d = S_ADD;
         end
         S_ADD: begin
            // The multiplier MSB carries negative weight, so its partial product is subtracted.
            if (step_q == LAST_STEP) Sub = M;
            else                     Add = M;
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            Shift_En = 1'b1;
            if (step_q == LAST_STEP) begin
               state_d = S_CAPT;
            end else begin
               step_d  = step_q + STEP_W'(1);
               state_d = S_ADD;
            end
         end
         S_CAPT: begin
            resp_data_d  = product_in;
            resp_valid_d = 1'b1;
            state_d      = S_RESP;
         end
         S_RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               job_count_d  = job_count_q + 16'd1;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q      <= S_IDLE;
         step_q       <= '0;
         last_grant_q <= 1'b1;
         dp_s_q       <= '0;
         dp_b_q       <= '0;
         resp_id_q    <= 1'b0;
         resp_data_q  <= '0;
         resp_valid_q <= 1'b0;
         job_count_q  <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         step_q       <= step_d;
         last_grant_q <= last_grant_d;
         dp_s_q       <= dp_s_d;
         dp_b_q       <= dp_b_d;
         resp_id_q    <= resp_id_d;
         resp_data_q  <= resp_data_d;
         resp_valid_q <= resp_valid_d;
         job_count_q  <= job_count_d;
         busy_q       <= (state_d != S_IDLE);
      end
   end

   assign dp_S       = dp_s_q;
   assign dp_B       = dp_b_q;
   assign resp_id    = resp_id_q;
   assign resp_data  = resp_data_q;
   assign resp_valid = resp_valid_q;
   assign job_count  = job_count_q;
   assign busy       = busy_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_mult_share_sequencer.sv
// Bench for mult_share_sequencer: a behavioural shift-add datapath closes the loop, and every
// response is scored against a plain signed-multiply model with an expected queue.
module tb_mult_share_sequencer;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic [1:0]  req_valid = 2'b00;
   logic [1:0]  req_ready;
   logic [7:0]  req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
   logic [7:0]  dp_S, dp_B;
   logic        Ld_B, Clr_XA, Add, Sub, Shift_En;
   logic        M;
   logic [15:0] product_in;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic        resp_id;
   logic [15:0] resp_data;
   logic        busy;
   logic [15:0] job_count;
   logic [2:0]  dbg_state;

   int          nvec = 0;
   int          nerr = 0;
   logic [16:0] exp_q[$];
   logic [15:0] exp_jobs = '0;

   mult_share_sequencer #(.WIDTH(8)) dut (
      .Clk(Clk), .Reset(Reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
      .dp_S(dp_S), .dp_B(dp_B),
      .Ld_B(Ld_B), .Clr_XA(Clr_XA), .Add(Add), .Sub(Sub), .Shift_En(Shift_En),
      .M(M), .product_in(product_in),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_id(resp_id), .resp_data(resp_data),
      .busy(busy), .job_count(job_count), .dbg_state(dbg_state)
   );

   always #5 Clk = ~Clk;

   // Datapath: X:A:B with A +/- S (sign into X) and arithmetic right shift of X:A:B.
   logic       dp_x_r = 1'b0;
   logic [7:0] dp_a_r = '0, dp_b_r = '0;
   logic [8:0] sum_add, sum_sub;
   always_comb begin
      sum_add = {dp_a_r[7], dp_a_r} + {dp_S[7], dp_S};
      sum_sub = {dp_a_r[7], dp_a_r} - {dp_S[7], dp_S};
   end
   always @(posedge Clk) begin
      if (Ld_B) dp_b_r <= dp_B;
      if (Clr_XA) begin
         dp_x_r <= 1'b0;
         dp_a_r <= '0;
      end else if (Add) begin
         dp_x_r <= sum_add[8];
         dp_a_r <= sum_add[7:0];
      end else if (Sub) begin
         dp_x_r <= sum_sub[8];
         dp_a_r <= sum_sub[7:0];
      end else if (Shift_En) begin
         dp_a_r <= {dp_x_r, dp_a_r[7:1]};
         dp_b_r <= {dp_a_r[0], dp_b_r[7:1]};
      end
   end
   assign M = dp_b_r[0];
   assign product_in = {dp_a_r, dp_b_r};

   always @(negedge Clk) begin
      if (Reset) begin
         nvec++;
         if ((int'(Ld_B) + int'(Add) + int'(Sub) + int'(Shift_En)) > 1 || Clr_XA !== Ld_B ||
             (Clr_XA && (Add || Sub || Shift_En))) begin
            nerr++;
            $display("FAIL ctrl_exclusive got Ld_B=%b Clr_XA=%b Add=%b Sub=%b Shift_En=%b want at most one (Ld_B with Clr_XA)",
                     Ld_B, Clr_XA, Add, Sub, Shift_En);
         end
      end
   end

   function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
      int p;
      p = int'($signed(a)) * int'($signed(b));
      return p[15:0];
   endfunction

   task automatic tick();
      @(posedge Clk);
      #2;
   endtask

   task automatic run_job(input logic id, input logic [7:0] a, input logic [7:0] b, input int hold,
                          output int wait_cyc, output int lat, output logic [15:0] data,
                          output logic rid, output logic held_ok);
      if (id) begin
         req_a1 = a; req_b1 = b; req_valid = 2'b10;
      end else begin
         req_a0 = a; req_b0 = b; req_valid = 2'b01;
      end
      #1;
      wait_cyc = 0; lat = -1; data = '0; rid = 1'b0; held_ok = 1'b0;
      while (req_ready[id] !== 1'b1 && wait_cyc < 100) begin
         tick();
         wait_cyc++;
      end
      if (req_ready[id] !== 1'b1) begin
         req_valid = 2'b00;
         return;
      end
      exp_q.push_back({id, ref_mul(a, b)});
      tick();
      req_valid = 2'b00;
      lat = 0;
      while (resp_valid !== 1'b1 && lat < 60) begin
         tick();
         lat++;
      end
      if (resp_valid !== 1'b1) begin
         lat = -1;
         return;
      end
      data = resp_data; rid = resp_id; held_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
         tick();
         if (resp_valid !== 1'b1 || resp_data !== data || resp_id !== rid || req_ready !== 2'b00)
            held_ok = 1'b0;
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      exp_jobs++;
   endtask

   task automatic test_reset();
      Reset = 1'b0; req_valid = 2'b00; resp_ready = 1'b0;
      repeat (3) tick();
      nvec++;
      if ({Ld_B, Clr_XA, Add, Sub, Shift_En} !== 5'b0) begin
         nerr++; $display("FAIL reset_ctrl got %b want 00000", {Ld_B, Clr_XA, Add, Sub, Shift_En});
      end
      nvec++;
      if ({busy, resp_valid, req_ready} !== 4'b0) begin
         nerr++; $display("FAIL reset_flags got %b want 0000", {busy, resp_valid, req_ready});
      end
      nvec++;
      if ({dp_S, dp_B, resp_data, resp_id, job_count} !== 49'b0) begin
         nerr++; $display("FAIL reset_regs got %h/%h/%h/%b/%h want all 0", dp_S, dp_B, resp_data, resp_id, job_count);
      end
      Reset = 1'b1;
      tick();
      exp_jobs = '0;
      exp_q.delete();
   endtask

   task automatic test_basic();
      int w, lat; logic [15:0] d; logic r, ok; logic [16:0] exp;
      run_job(1'b0, 8'd7, 8'd3, 0, w, lat, d, r, ok);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      nvec++;
      if (w !== 0) begin nerr++; $display("FAIL basic_ready_wait got %0d want 0", w); end
      nvec++;
      if (lat !== 18) begin nerr++; $display("FAIL basic_latency got %0d want 18", lat); end
      nvec++;
      if ({r, d} !== exp || d !== 16'h0015) begin
         nerr++; $display("FAIL basic_result got %b/%h want 0/0015", r, d);
      end
      nvec++;
      if (job_count !== 16'd1 || resp_valid !== 1'b0) begin
         nerr++; $display("FAIL basic_job_count got %0d valid=%b want 1 valid=0", job_count, resp_valid);
      end
   endtask

   task automatic test_signed();
      logic [24:0] tbl [3];
      int w, lat; logic [15:0] d; logic r, ok; logic [16:0] exp;
      tbl[0] = {1'b1, 8'hFD, 8'h05, 8'h00};
      tbl[1] = {1'b0, 8'h80, 8'h80, 8'h00};
      tbl[2] = {1'b1, 8'h05, 8'hFD, 8'h00};
      for (int i = 0; i < 3; i++) begin
         run_job(tbl[i][24], tbl[i][23:16], tbl[i][15:8], 0, w, lat, d, r, ok);
         exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
         nvec++;
         if (lat !== 18) begin nerr++; $display("FAIL signed_latency[%0d] got %0d want 18", i, lat); end
         nvec++;
         if ({r, d} !== exp) begin
            nerr++; $display("FAIL signed_result[%0d] got %b/%h want %b/%h", i, r, d, exp[16], exp[15:0]);
         end
         nvec++;
         if (job_count !== exp_jobs) begin
            nerr++; $display("FAIL signed_job_count[%0d] got %0d want %0d", i, job_count, exp_jobs);
         end
      end
   endtask

   task automatic test_random();
      int w, lat, hold; logic [15:0] d; logic r, ok, id; logic [7:0] a, b; logic [16:0] exp;
      for (int i = 0; i < 10; i++) begin
         id = 1'($urandom_range(0, 1));
         a = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(0, 255));
         hold = $urandom_range(0, 3);
         run_job(id, a, b, hold, w, lat, d, r, ok);
         exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
         nvec++;
         if ({r, d} !== exp || lat !== 18) begin
            nerr++; $display("FAIL rand_result[%0d] got %b/%h lat %0d want %b/%h lat 18", i, r, d, lat, exp[16], exp[15:0]);
         end
         nvec++;
         if (ok !== 1'b1 || job_count !== exp_jobs) begin
            nerr++; $display("FAIL rand_hold_count[%0d] got held=%b count=%0d want 1/%0d", i, ok, job_count, exp_jobs);
         end
      end
   endtask

   task automatic test_round_robin();
      int n_acc, prev; logic gid, acc_now; logic [16:0] exp; logic [1:0] want;
      Reset = 1'b0;
      req_a0 = 8'd9;  req_b0 = 8'hF9;
      req_a1 = 8'hE0; req_b1 = 8'd6;
      req_valid = 2'b11;
      repeat (2) tick();
      Reset = 1'b1;
      exp_jobs = '0; exp_q.delete();
      resp_ready = 1'b1;
      n_acc = 0; prev = 0; gid = 1'b0;
      for (int c = 0; c < 150 && n_acc < 4; c++) begin
         acc_now = 1'b0;
         if (resp_valid === 1'b1) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            exp_jobs++;
            nvec++;
            if ({resp_id, resp_data} !== exp) begin
               nerr++; $display("FAIL rr_result got %b/%h want %b/%h", resp_id, resp_data, exp[16], exp[15:0]);
            end
         end
         if (req_ready !== 2'b00) begin
            want = (n_acc % 2 == 0) ? 2'b01 : 2'b10;
            nvec++;
            if (req_ready !== want) begin nerr++; $display("FAIL rr_grant[%0d] got %b want %b", n_acc, req_ready, want); end
            if (n_acc > 0) begin
               nvec++;
               if (c - prev !== 20) begin nerr++; $display("FAIL rr_spacing[%0d] got %0d want 20", n_acc, c - prev); end
            end
            prev = c;
            gid = req_ready[1];
            exp_q.push_back({gid, gid ? ref_mul(req_a1, req_b1) : ref_mul(req_a0, req_b0)});
            n_acc++;
            acc_now = 1'b1;
         end
         tick();
         if (acc_now) begin
            if (gid) begin req_a1 = 8'($urandom); req_b1 = 8'($urandom); end
            else     begin req_a0 = 8'($urandom); req_b0 = 8'($urandom); end
         end
      end
      req_valid = 2'b00;
      nvec++;
      if (n_acc !== 4) begin nerr++; $display("FAIL rr_accepts got %0d want 4", n_acc); end
      for (int c = 0; c < 40 && resp_valid !== 1'b1; c++) tick();
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      nvec++;
      if (resp_valid !== 1'b1 || {resp_id, resp_data} !== exp) begin
         nerr++; $display("FAIL rr_last_result got %b %b/%h want 1 %b/%h", resp_valid, resp_id, resp_data, exp[16], exp[15:0]);
      end
      tick();
      exp_jobs++;
      resp_ready = 1'b0;
      nvec++;
      if (job_count !== exp_jobs || exp_jobs !== 16'd4) begin
         nerr++; $display("FAIL rr_job_count got %0d want 4", job_count);
      end
   endtask

   task automatic test_backpressure();
      logic [16:0] exp; logic [15:0] snap_d; logic snap_i, ok; int n;
      req_a0 = 8'h9C; req_b0 = 8'h27; req_valid = 2'b01;
      #1;
      for (n = 0; n < 100 && req_ready[0] !== 1'b1; n++) tick();
      exp_q.push_back({1'b0, ref_mul(8'h9C, 8'h27)});
      tick();
      req_a1 = 8'h11; req_b1 = 8'hF0; req_valid = 2'b10;
      ok = 1'b1;
      for (n = 0; n < 60 && resp_valid !== 1'b1; n++) begin
         if (req_ready !== 2'b00) ok = 1'b0;
         tick();
      end
      snap_d = resp_data; snap_i = resp_id;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (resp_valid !== 1'b1 || resp_data !== snap_d || resp_id !== snap_i || req_ready !== 2'b00) ok = 1'b0;
      end
      nvec++;
      if (ok !== 1'b1) begin nerr++; $display("FAIL bp_hold_stable got 0 want 1"); end
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      nvec++;
      if ({snap_i, snap_d} !== exp) begin
         nerr++; $display("FAIL bp_result got %b/%h want %b/%h", snap_i, snap_d, exp[16], exp[15:0]);
      end
      resp_ready = 1'b1;
      #1;
      nvec++;
      if (req_ready !== 2'b00) begin nerr++; $display("FAIL bp_no_accept_in_resp got %b want 00", req_ready); end
      tick();
      resp_ready = 1'b0;
      exp_jobs++;
      nvec++;
      if ({resp_valid, busy, req_ready} !== 4'b0010) begin
         nerr++; $display("FAIL bp_idle_cycle got valid=%b busy=%b ready=%b want 0/0/10", resp_valid, busy, req_ready);
      end
      exp_q.push_back({1'b1, ref_mul(8'h11, 8'hF0)});
      tick();
      req_valid = 2'b00;
      nvec++;
      if ({busy, req_ready} !== 3'b100) begin
         nerr++; $display("FAIL bp_second_accept got busy=%b ready=%b want 1/00", busy, req_ready);
      end
      for (n = 0; n < 60 && resp_valid !== 1'b1; n++) tick();
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      nvec++;
      if ({resp_id, resp_data} !== exp) begin
         nerr++; $display("FAIL bp_second_result got %b/%h want %b/%h", resp_id, resp_data, exp[16], exp[15:0]);
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      exp_jobs++;
      nvec++;
      if (job_count !== exp_jobs) begin nerr++; $display("FAIL bp_job_count got %0d want %0d", job_count, exp_jobs); end
   endtask

   task automatic test_reset_mid_job();
      int w, lat, n; logic [15:0] d; logic r, ok, seen; logic [16:0] exp;
      req_a0 = 8'h55; req_b0 = 8'h3C; req_valid = 2'b01;
      #1;
      for (n = 0; n < 100 && req_ready[0] !== 1'b1; n++) tick();
      tick();
      req_valid = 2'b00;
      repeat (8) tick();
      nvec++;
      if (Shift_En !== 1'b1 || busy !== 1'b1) begin
         nerr++; $display("FAIL mid_in_shift got shift=%b busy=%b want 1/1", Shift_En, busy);
      end
      Reset = 1'b0;
      tick();
      nvec++;
      if ({Ld_B, Clr_XA, Add, Sub, Shift_En, busy, resp_valid, req_ready} !== 9'b0 ||
          {dp_S, dp_B, resp_data, resp_id, job_count} !== 49'b0) begin
         nerr++; $display("FAIL mid_reset_outputs got ctrl=%b busy=%b valid=%b data=%h count=%0d want all 0",
                          {Ld_B, Clr_XA, Add, Sub, Shift_En}, busy, resp_valid, resp_data, job_count);
      end
      Reset = 1'b1;
      exp_q.delete();
      exp_jobs = '0;
      seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (resp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      end
      nvec++;
      if (seen !== 1'b0) begin nerr++; $display("FAIL mid_no_resp got activity=1 want 0"); end
      run_job(1'b1, 8'd12, 8'hFE, 1, w, lat, d, r, ok);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      nvec++;
      if ({r, d} !== exp || d !== 16'hFFE8 || lat !== 18) begin
         nerr++; $display("FAIL mid_after_result got %b/%h lat %0d want 1/ffe8 lat 18", r, d, lat);
      end
      nvec++;
      if (job_count !== 16'd1) begin nerr++; $display("FAIL mid_after_count got %0d want 1", job_count); end
   endtask

   task automatic test_wrap();
      int w, lat; logic [15:0] d; logic r, ok; logic [16:0] exp;
      @(negedge Clk);
      force dut.job_count_q = 16'hFFFF;
      #1;
      release dut.job_count_q;
      exp_jobs = 16'hFFFF;
      nvec++;
      if (job_count !== 16'hFFFF) begin nerr++; $display("FAIL wrap_preload got %h want ffff", job_count); end
      run_job(1'b0, 8'($urandom), 8'($urandom), 0, w, lat, d, r, ok);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      nvec++;
      if ({r, d} !== exp) begin
         nerr++; $display("FAIL wrap_result got %b/%h want %b/%h", r, d, exp[16], exp[15:0]);
      end
      nvec++;
      if (job_count !== exp_jobs || exp_jobs !== 16'h0000) begin
         nerr++; $display("FAIL wrap_count got %h want 0000", job_count);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signed();
      test_random();
      test_round_robin();
      test_backpressure();
      test_reset_mid_job();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #500000;
      nerr++;
      $display("FAIL watchdog got timeout want completion");
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
